// File: rtl/registrador_instrucoes_multi_if.sv
// registrador_instrucoes_multi_if: bus-side signals of the multi-byte instruction register.
// RI_LEN_CHECK_EN adds the sticky err flag.
interface registrador_instrucoes_multi_if #(
  parameter int WORD_W    = 8,
  parameter int OPC_W     = 4,
  parameter int MAX_BYTES = 3
);
  localparam int OPR_W = WORD_W*(MAX_BYTES-1);
  logic [WORD_W-1:0] d;
  logic              n_l1;
  logic              n_e1;
  logic [1:0]        inst_len;
  logic [OPC_W-1:0]  opcode;
  logic [OPR_W-1:0]  s;
  logic              ready;
  logic              busy;
`ifdef RI_LEN_CHECK_EN
  logic              err;
`endif
  modport master (
    output d, n_l1, n_e1, inst_len,
`ifdef RI_LEN_CHECK_EN
    input  err,
`endif
    input  opcode, s, ready, busy
  );
  modport slave (
    input  d, n_l1, n_e1, inst_len,
`ifdef RI_LEN_CHECK_EN
    output err,
`endif
    output opcode, s, ready, busy
  );
endinterface

// File: rtl/registrador_instrucoes_multi.sv
// registrador_instrucoes_multi: instruction register assembling an opcode byte plus LSB-first operand bytes.
// RI_LEN_CHECK_EN adds a sticky err flag for out-of-range inst_len.
module registrador_instrucoes_multi #(
  parameter int WORD_W    = 8,
  parameter int OPC_W     = 4,
  parameter int MAX_BYTES = 3
)(
  input logic clk,
  input logic clr,
  registrador_instrucoes_multi_if.slave bus
);
  localparam int OPR_W = WORD_W*(MAX_BYTES-1);
  localparam int SH_W  = WORD_W-OPC_W;
  typedef enum logic [1:0] {IDLE, ASSEMBLE, READY} state_t;
  state_t            state, state_nx;
  logic [OPC_W-1:0]  opc;
  logic [SH_W-1:0]   short_f;
  logic [OPR_W-1:0]  opr;
  logic [1:0]        rem, idx;
  logic              multi;
  logic              load, start;
  logic [2:0]        len_l;
  assign load  = ~bus.n_l1;
  assign start = load && state != ASSEMBLE;
  assign len_l = bus.inst_len == 2'd0 ? 3'd1 :
                 ({1'b0, bus.inst_len} > 3'(MAX_BYTES) ? 3'(MAX_BYTES) : {1'b0, bus.inst_len});
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = start ? (len_l == 3'd1 ? READY : ASSEMBLE) :
               (load && state == ASSEMBLE && rem == 2'd1) ? READY : state;
  end
  always_comb begin
    bus.ready = state == READY;
    bus.busy  = state == ASSEMBLE;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      opc     <= '0;
      short_f <= '0;
      opr     <= '0;
      rem     <= '0;
      idx     <= '0;
      multi   <= 1'b0;
    end else if (start) begin
      opc     <= bus.d[WORD_W-1 -: OPC_W];
      short_f <= bus.d[SH_W-1:0];
      opr     <= '0;
      rem     <= 2'(len_l - 3'd1);
      idx     <= '0;
      multi   <= len_l != 3'd1;
    end else if (load) begin
      for (int k = 0; k < MAX_BYTES-1; k++)
        if (idx == 2'(k)) opr[WORD_W*k +: WORD_W] <= bus.d;
      idx <= idx + 2'd1;
      rem <= rem - 2'd1;
    end
  end
  // single-byte instructions expose the opcode byte's low field as the operand
  assign bus.s      = bus.n_e1 ? '0 : (multi ? opr : OPR_W'(short_f));
  assign bus.opcode = opc;
`ifdef RI_LEN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge clr)
    if (clr) err_q <= 1'b0;
    else     err_q <= err_q | (start && (bus.inst_len == 2'd0 || {1'b0, bus.inst_len} > 3'(MAX_BYTES)));
  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_registrador_instrucoes_multi.sv
// tb_registrador_instrucoes_multi: directed checks on a default instance and a MAX_BYTES=2 instance.
module tb_registrador_instrucoes_multi;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   passes = 0;
  int   total  = 0;
  always #5 clk = ~clk;
  registrador_instrucoes_multi_if bus_a ();
  registrador_instrucoes_multi_if #(.MAX_BYTES(2)) bus_b ();
  registrador_instrucoes_multi dut_a (.clk(clk), .clr(clr), .bus(bus_a));
  registrador_instrucoes_multi #(.MAX_BYTES(2)) dut_b (.clk(clk), .clr(clr), .bus(bus_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic ld_a(input logic [7:0] d, input logic [1:0] len);
    bus_a.d = d; bus_a.inst_len = len; bus_a.n_l1 = 1'b0;
    @(posedge clk); #1;
    bus_a.n_l1 = 1'b1;
  endtask
  task automatic ld_b(input logic [7:0] d, input logic [1:0] len);
    bus_b.d = d; bus_b.inst_len = len; bus_b.n_l1 = 1'b0;
    @(posedge clk); #1;
    bus_b.n_l1 = 1'b1;
  endtask
  initial begin
    bus_a.d = '0; bus_a.n_l1 = 1'b1; bus_a.n_e1 = 1'b0; bus_a.inst_len = '0;
    bus_b.d = '0; bus_b.n_l1 = 1'b1; bus_b.n_e1 = 1'b0; bus_b.inst_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_opcode", bus_a.opcode, 0);
    chk("rst_s", bus_a.s, 0);
    chk("rst_ready", bus_a.ready, 0);
    chk("rst_busy", bus_a.busy, 0);
    clr = 1'b0;
    ld_a(8'h2E, 2'd1);
    chk("l1_opcode", bus_a.opcode, 4'h2);
    chk("l1_s", bus_a.s, 16'h000E);
    chk("l1_ready", bus_a.ready, 1);
    chk("l1_busy", bus_a.busy, 0);
    ld_a(8'hC0, 2'd3);
    chk("l3a_busy", bus_a.busy, 1);
    chk("l3a_ready", bus_a.ready, 0);
    chk("l3a_opcode", bus_a.opcode, 4'hC);
    chk("l3a_s", bus_a.s, 16'h0000);
    ld_a(8'h34, 2'd0);
    chk("l3b_busy", bus_a.busy, 1);
    chk("l3b_s_partial", bus_a.s, 16'h0034);
    ld_a(8'h12, 2'd0);
    chk("l3c_ready", bus_a.ready, 1);
    chk("l3c_busy", bus_a.busy, 0);
    chk("l3c_opcode", bus_a.opcode, 4'hC);
    chk("l3c_s", bus_a.s, 16'h1234);
    bus_a.d = 8'hFF; bus_a.inst_len = 2'd1;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_opcode", bus_a.opcode, 4'hC);
    chk("hold_s", bus_a.s, 16'h1234);
    chk("hold_ready", bus_a.ready, 1);
    bus_a.n_e1 = 1'b1; #1;
    chk("ne1_s", bus_a.s, 16'h0000);
    chk("ne1_ready", bus_a.ready, 1);
    chk("ne1_opcode", bus_a.opcode, 4'hC);
    bus_a.n_e1 = 1'b0;
    ld_a(8'h3F, 2'd1);
    chk("rdy_opcode", bus_a.opcode, 4'h3);
    chk("rdy_s", bus_a.s, 16'h000F);
    chk("rdy_ready", bus_a.ready, 1);
    ld_a(8'h50, 2'd2);
    chk("l2a_busy", bus_a.busy, 1);
    chk("l2a_s", bus_a.s, 16'h0000);
    ld_a(8'hAB, 2'd0);
    chk("l2b_ready", bus_a.ready, 1);
    chk("l2b_s", bus_a.s, 16'h00AB);
    chk("l2b_opcode", bus_a.opcode, 4'h5);
    ld_a(8'h9A, 2'd0);
    chk("len0_ready", bus_a.ready, 1);
    chk("len0_opcode", bus_a.opcode, 4'h9);
    chk("len0_s", bus_a.s, 16'h000A);
    ld_a(8'hC0, 2'd3);
    ld_a(8'h34, 2'd0);
    #2 clr = 1'b1; #1;
    chk("clr_opcode", bus_a.opcode, 0);
    chk("clr_s", bus_a.s, 0);
    chk("clr_busy", bus_a.busy, 0);
    chk("clr_ready", bus_a.ready, 0);
    @(negedge clk);
    clr = 1'b0;
    ld_a(8'h15, 2'd1);
    chk("post_clr_opcode", bus_a.opcode, 4'h1);
    chk("post_clr_s", bus_a.s, 16'h0005);
    chk("post_clr_ready", bus_a.ready, 1);
    ld_b(8'hA0, 2'd3);
    chk("b_clamp_busy", bus_b.busy, 1);
    chk("b_clamp_opcode", bus_b.opcode, 4'hA);
`ifdef RI_LEN_CHECK_EN
    chk("b_err_set", bus_b.err, 1);
`endif
    ld_b(8'h7F, 2'd0);
    chk("b_ready", bus_b.ready, 1);
    chk("b_s", bus_b.s, 8'h7F);
    ld_b(8'h21, 2'd1);
    chk("b_l1_s", bus_b.s, 8'h01);
    chk("b_l1_ready", bus_b.ready, 1);
`ifdef RI_LEN_CHECK_EN
    chk("b_err_sticky", bus_b.err, 1);
    clr = 1'b1; #1;
    chk("b_err_clr", bus_b.err, 0);
    clr = 1'b0;
`endif
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/registrador_instrucoes_multi.md
REGISTRADOR_INSTRUCOES_MULTI -- requirements
Module: registrador_instrucoes_multi

Interface
REQ-001 Parameter WORD_W, default 8, bus/byte width in bits.
REQ-002 Parameter OPC_W, default 4, opcode width in bits, taken from the top of the first byte; range 1..WORD_W-1.
REQ-003 Parameter MAX_BYTES, default 3, maximum instruction length in bytes; range 2..4.
REQ-004 Derived OPR_W = WORD_W*(MAX_BYTES-1), operand width.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 clr  in  1  reset; asynchronous, active-high.
REQ-007 d  in  WORD_W  byte from the bus.
REQ-008 n_l1  in  1  load enable, active-low; sampled on rising edge of clk.
REQ-009 n_e1  in  1  operand output enable, active-low.
REQ-010 inst_len  in  2  length in bytes of the instruction whose opcode byte is on d; sampled only with the opcode byte.
REQ-011 opcode  out  OPC_W  registered opcode.
REQ-012 s  out  OPR_W  operand output to the bus; zero when n_e1=1.
REQ-013 ready  out  1  1 = complete instruction held.
REQ-014 busy  out  1  1 = operand bytes still expected.
REQ-015 err  out  1  sticky illegal-length flag; present only with RI_LEN_CHECK_EN.

Function
REQ-016 The FSM SHALL have the states IDLE, ASSEMBLE and READY; ready=1 only in READY; busy=1 only in ASSEMBLE.
REQ-017 Load occurs on a rising edge with n_l1=0; n_l1=1 holds all registers.
REQ-018 Load in IDLE or READY: opcode<=d[WORD_W-1:WORD_W-OPC_W]; short field<=d[WORD_W-OPC_W-1:0]; operand register<=0; remaining<=L-1; next state READY if L=1, else ASSEMBLE.
REQ-019 L = inst_len, except that 0 maps to 1 and values above MAX_BYTES map to MAX_BYTES.
REQ-020 Load in ASSEMBLE: byte k (k=0 is the first operand byte) SHALL be written to operand bits [WORD_W*(k+1)-1 : WORD_W*k], least-significant byte first; remaining decrements; at remaining=1 the next state is READY.
REQ-021 Latency: ready rises on the edge that loads the last byte; a 1-byte instruction gives ready=1 one edge after its load.
REQ-022 A load in READY starts a new instruction in that same edge; opcode and operand change together; there is no cycle with ready=0 if L=1.
REQ-023 Operand value: for L=1 it SHALL be the short field zero-extended to OPR_W (SAP-1 compatible); for L>1 it SHALL be the assembled operand with unloaded upper bytes zero.
REQ-024 s is combinational: operand value when n_e1=0, otherwise all zeros; n_e1 SHALL NOT affect state.
REQ-025 In ASSEMBLE, s SHALL show the partial operand; the consumer gates on ready.
REQ-026 opcode is always driven, independent of n_e1.

Reset
REQ-027 clr=1 SHALL immediately force state IDLE, opcode=0, operand=0, short field=0, remaining=0, ready=0, busy=0, err=0, and s=0.
REQ-028 clr asserted mid-ASSEMBLE discards the partial instruction; the first load after release is treated as an opcode byte.

Configuration
REQ-029 With RI_LEN_CHECK_EN defined: a load in IDLE/READY with inst_len=0 or inst_len>MAX_BYTES SHALL set err=1, which stays set until clr; the REQ-019 clamping still applies.
REQ-030 Without RI_LEN_CHECK_EN: the err port and its logic are absent; clamping is silent.

Verification
REQ-031 Defaults; clr pulse, then load d=8'h2E, inst_len=1, n_e1=0 -> after 1 edge: opcode=4'h2, s=16'h000E, ready=1, busy=0.
REQ-032 Load 8'hC0 (len 3), 8'h34, 8'h12 on consecutive edges -> busy=1 for 2 cycles; ready=1 after the 3rd edge; opcode=4'hC, s=16'h1234.
REQ-033 Hold n_l1=1 for 5 cycles after REQ-032 -> all outputs unchanged; n_e1=1 -> s=16'h0000 with ready still 1.
REQ-034 Load 8'hC0 (len 3), 8'h34, then clr mid-cycle -> immediately state IDLE, all outputs 0; next load 8'h15 (len 1) -> opcode=4'h1, s=16'h0005.
REQ-035 With RI_LEN_CHECK_EN and MAX_BYTES=2: load 8'hA0 with inst_len=3 -> err=1, busy=1 (L=2); then load 8'h7F -> ready=1, s=8'h7F, err stays 1 until clr.
REQ-036 In READY, load 8'h3F (len 1) -> same edge: opcode=4'h3, s=0x000F, ready stays 1 with no gap.
